// File: rtl/pe_42_d_pkg.sv
// Shared definitions for the registered 4-to-2 priority encoder.
// The MULTI field exists only when PE_42_D_MULTI_EN is defined.
package pe_42_d_pkg;

  localparam logic [1:0] CODE_Y0 = 2'b00;
  localparam logic [1:0] CODE_Y1 = 2'b01;
  localparam logic [1:0] CODE_Y2 = 2'b10;
  localparam logic [1:0] CODE_Y3 = 2'b11;

  typedef struct packed {
    logic [1:0] code;
    logic       valid;
`ifdef PE_42_D_MULTI_EN
    logic       multi;
`endif
  } pe_out_t;

  localparam pe_out_t OUT_RESET = '0;

endpackage

// File: rtl/pe_42_d_if.sv
// Request/encoded-index bundle for pe_42_d; the master drives requests, the encoder is the slave.
// MULTI is present only when PE_42_D_MULTI_EN is defined.
interface pe_42_d_if;

  logic Y0;
  logic Y1;
  logic Y2;
  logic Y3;
  logic A0;
  logic A1;
  logic V;
`ifdef PE_42_D_MULTI_EN
  logic MULTI;
`endif

  modport master (
    output Y0, Y1, Y2, Y3,
`ifdef PE_42_D_MULTI_EN
    input  MULTI,
`endif
    input  A0, A1, V
  );

  modport slave (
    input  Y0, Y1, Y2, Y3,
`ifdef PE_42_D_MULTI_EN
    output MULTI,
`endif
    output A0, A1, V
  );

endinterface

// File: rtl/pe_42_d_comb.sv
// Combinational core of the priority encoder: selects the winning request line.
// The multi-request detector is built only when PE_42_D_MULTI_EN is defined.
module pe_42_d_comb
  import pe_42_d_pkg::*;
#(
  parameter int unsigned PRIO_HIGH = 1
) (
  input  logic       Y0_i,
  input  logic       Y1_i,
  input  logic       Y2_i,
  input  logic       Y3_i,
`ifdef PE_42_D_MULTI_EN
  output logic       nextMulti_o,
`endif
  output logic [1:0] nextA_o,
  output logic       nextV_o
);

  logic [3:0] req;

  assign req = {Y3_i, Y2_i, Y1_i, Y0_i};

  // The code of each line equals its own index; only the scan order flips with PRIO_HIGH.
  always_comb begin
    nextA_o = CODE_Y0;
    if (PRIO_HIGH != 0) begin
      if (req[3])      nextA_o = CODE_Y3;
      else if (req[2]) nextA_o = CODE_Y2;
      else if (req[1]) nextA_o = CODE_Y1;
      else             nextA_o = CODE_Y0;
    end else begin
      if (req[0])      nextA_o = CODE_Y0;
      else if (req[1]) nextA_o = CODE_Y1;
      else if (req[2]) nextA_o = CODE_Y2;
      else if (req[3]) nextA_o = CODE_Y3;
      else             nextA_o = CODE_Y0;
    end
  end

  assign nextV_o = |req;

`ifdef PE_42_D_MULTI_EN
  // Clearing the lowest set bit leaves something only if two or more lines are high.
  assign nextMulti_o = |(req & (req - 4'd1));
`endif

endmodule

// File: rtl/pe_42_d.sv
// Registered 4-to-2 priority encoder with valid flag, one cycle of latency.
// Optional MULTI output enabled by defining PE_42_D_MULTI_EN.
module pe_42_d
  import pe_42_d_pkg::*;
#(
  parameter int unsigned PRIO_HIGH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  pe_42_d_if.slave bus
);

  pe_out_t outD;
  pe_out_t outQ;

  pe_42_d_comb #(
    .PRIO_HIGH (PRIO_HIGH)
  ) u_comb (
    .Y0_i        (bus.Y0),
    .Y1_i        (bus.Y1),
    .Y2_i        (bus.Y2),
    .Y3_i        (bus.Y3),
`ifdef PE_42_D_MULTI_EN
    .nextMulti_o (outD.multi),
`endif
    .nextA_o     (outD.code),
    .nextV_o     (outD.valid)
  );

  // Output register; reset clears everything immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outQ <= OUT_RESET;
    end else begin
      outQ <= outD;
    end
  end

  assign bus.A0 = outQ.code[0];
  assign bus.A1 = outQ.code[1];
  assign bus.V  = outQ.valid;
`ifdef PE_42_D_MULTI_EN
  assign bus.MULTI = outQ.multi;
`endif

endmodule

// File: tb/tb_pe_42_d.sv
// Directed self-checking bench for pe_42_d, running both priority directions side by side.
// MULTI checks are compiled in when PE_42_D_MULTI_EN is defined.
module tb_pe_42_d;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  pe_42_d_if busHi ();
  pe_42_d_if busLo ();

  pe_42_d #(.PRIO_HIGH(1)) dutHi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busHi.slave)
  );

  pe_42_d #(.PRIO_HIGH(0)) dutLo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busLo.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setY(input logic [3:0] y);
    {busHi.Y3, busHi.Y2, busHi.Y1, busHi.Y0} = y;
    {busLo.Y3, busLo.Y2, busLo.Y1, busLo.Y0} = y;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    setY(4'b1000);
    #1;
    for (int k = 0; k < 3; k++) begin
      compared++;
      if ({busHi.A1, busHi.A0, busHi.V} !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL reset_hi: got A/V=%b expected 000", {busHi.A1, busHi.A0, busHi.V});
      end
      compared++;
      if ({busLo.A1, busLo.A0, busLo.V} !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL reset_lo: got A/V=%b expected 000", {busLo.A1, busLo.A0, busLo.V});
      end
`ifdef PE_42_D_MULTI_EN
      compared++;
      if (busHi.MULTI !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_multi: got %b expected 0", busHi.MULTI);
      end
`endif
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if ({busHi.A1, busHi.A0, busHi.V} !== 3'b111) begin
      mismatched++;
      $display("[TB] FAIL reset_release: got A/V=%b expected 111", {busHi.A1, busHi.A0, busHi.V});
    end
  endtask

  task automatic test_onehot_sweep();
    logic [2:0] prevHi;
    logic [2:0] expHi;
    prevHi = 3'b111;
    for (int i = 0; i < 4; i++) begin
      expHi = {i[1:0], 1'b1};
      @(negedge clk);
      setY(4'b0001 << i);
      #1;
      compared++;
      if ({busHi.A1, busHi.A0, busHi.V} !== prevHi) begin
        mismatched++;
        $display("[TB] FAIL onehot_latency[%0d]: got A/V=%b expected %b", i, {busHi.A1, busHi.A0, busHi.V}, prevHi);
      end
      @(posedge clk);
      #1;
      compared++;
      if ({busHi.A1, busHi.A0, busHi.V} !== expHi) begin
        mismatched++;
        $display("[TB] FAIL onehot_hi[%0d]: got A/V=%b expected %b", i, {busHi.A1, busHi.A0, busHi.V}, expHi);
      end
      compared++;
      if ({busLo.A1, busLo.A0, busLo.V} !== expHi) begin
        mismatched++;
        $display("[TB] FAIL onehot_lo[%0d]: got A/V=%b expected %b", i, {busLo.A1, busLo.A0, busLo.V}, expHi);
      end
`ifdef PE_42_D_MULTI_EN
      compared++;
      if (busHi.MULTI !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL onehot_multi[%0d]: got %b expected 0", i, busHi.MULTI);
      end
`endif
      repeat (9) @(posedge clk);
      #1;
      compared++;
      if ({busHi.A1, busHi.A0, busHi.V} !== expHi) begin
        mismatched++;
        $display("[TB] FAIL onehot_hold[%0d]: got A/V=%b expected %b", i, {busHi.A1, busHi.A0, busHi.V}, expHi);
      end
      prevHi = expHi;
    end
  endtask

  task automatic test_all_zero();
    @(negedge clk);
    setY(4'b0000);
    @(posedge clk);
    #1;
    compared++;
    if ({busHi.A1, busHi.A0, busHi.V} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL zero_hi: got A/V=%b expected 000", {busHi.A1, busHi.A0, busHi.V});
    end
    compared++;
    if ({busLo.A1, busLo.A0, busLo.V} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL zero_lo: got A/V=%b expected 000", {busLo.A1, busLo.A0, busLo.V});
    end
  endtask

  task automatic test_multi_pattern(input string name, input logic [3:0] y,
                                    input logic [2:0] expHi, input logic [2:0] expLo);
    @(negedge clk);
    setY(y);
    @(posedge clk);
    #1;
    compared++;
    if ({busHi.A1, busHi.A0, busHi.V} !== expHi) begin
      mismatched++;
      $display("[TB] FAIL %s_hi: got A/V=%b expected %b", name, {busHi.A1, busHi.A0, busHi.V}, expHi);
    end
    compared++;
    if ({busLo.A1, busLo.A0, busLo.V} !== expLo) begin
      mismatched++;
      $display("[TB] FAIL %s_lo: got A/V=%b expected %b", name, {busLo.A1, busLo.A0, busLo.V}, expLo);
    end
`ifdef PE_42_D_MULTI_EN
    compared++;
    if (busHi.MULTI !== 1'b1 || busLo.MULTI !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL %s_multi: got hi=%b lo=%b expected 1", name, busHi.MULTI, busLo.MULTI);
    end
`endif
  endtask

  task automatic test_conflict();
    test_multi_pattern("conflict", 4'b0101, 3'b101, 3'b001);
  endtask

  task automatic test_all_ones();
    test_multi_pattern("allones", 4'b1111, 3'b111, 3'b001);
  endtask

  task automatic test_async_reset_midstream();
    @(negedge clk);
    setY(4'b1000);
    @(posedge clk);
    #1;
    compared++;
    if ({busHi.A1, busHi.A0, busHi.V} !== 3'b111) begin
      mismatched++;
      $display("[TB] FAIL midreset_pre: got A/V=%b expected 111", {busHi.A1, busHi.A0, busHi.V});
    end
    #1;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({busHi.A1, busHi.A0, busHi.V, busLo.V} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL midreset_clear: got A/V/Vlo=%b expected 0000", {busHi.A1, busHi.A0, busHi.V, busLo.V});
    end
`ifdef PE_42_D_MULTI_EN
    compared++;
    if (busLo.MULTI !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_multi: got %b expected 0", busLo.MULTI);
    end
`endif
    #1;
    rst_n = 1'b1;
    #1;
    compared++;
    if ({busHi.A1, busHi.A0, busHi.V} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL midreset_hold: got A/V=%b expected 000", {busHi.A1, busHi.A0, busHi.V});
    end
    @(posedge clk);
    #1;
    compared++;
    if ({busHi.A1, busHi.A0, busHi.V} !== 3'b111) begin
      mismatched++;
      $display("[TB] FAIL midreset_release: got A/V=%b expected 111", {busHi.A1, busHi.A0, busHi.V});
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    setY(4'b0000);
    test_reset();
    test_onehot_sweep();
    test_all_zero();
    test_conflict();
    test_all_ones();
    test_async_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
